// File: rtl/fsic_io_serdes_pkg.sv
// fsic_io_serdes_pkg: shared types and constants for the IO serdes link bring-up sequencer.
//   state_t        sequencer states
//   ERR_*          err_code encodings reported to the system controller
//   CTRL_*_BIT     bit positions inside the serdes control register
package fsic_io_serdes_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_RX,
      ST_RD_RX,
      ST_WAIT,
      ST_WR_TX,
      ST_RD_TX,
      ST_DONE,
      ST_ERR
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_RETRY   = 2'b10;

   localparam int CTRL_RXEN_BIT = 0;
   localparam int CTRL_TXEN_BIT = 1;

endpackage

// File: rtl/fsic_axil_single_xfer.sv
// fsic_axil_single_xfer: performs one AXI-Lite write or read for as long as req is held.
//   axi_clk, axi_reset_n   clock, async active-low reset
//   req, we                transfer request (held until ack/timeout), 1 = write
//   addr, wdata            DW address and write data
//   ack                    one-cycle pulse: write handshake or read data accepted
//   rdata                  read data, valid with ack on a read
//   timeout                a handshake has stalled pTIMEOUT cycles
//   axi_*                  AXI-Lite master channels
module fsic_axil_single_xfer #(
   parameter int pADDR_WIDTH = 10,
   parameter int pDATA_WIDTH = 32,
   parameter int pTIMEOUT    = 255
) (
   input  logic                     axi_clk,
   input  logic                     axi_reset_n,
   input  logic                     req,
   input  logic                     we,
   input  logic [pADDR_WIDTH-1:0]   addr,
   input  logic [pDATA_WIDTH-1:0]   wdata,
   output logic                     ack,
   output logic [pDATA_WIDTH-1:0]   rdata,
   output logic                     timeout,
   output logic                     axi_awvalid,
   output logic [pADDR_WIDTH-1:0]   axi_awaddr,
   input  logic                     axi_awready,
   output logic                     axi_wvalid,
   output logic [pDATA_WIDTH-1:0]   axi_wdata,
   output logic [pDATA_WIDTH/8-1:0] axi_wstrb,
   input  logic                     axi_wready,
   output logic                     axi_arvalid,
   output logic [pADDR_WIDTH-1:0]   axi_araddr,
   input  logic                     axi_arready,
   input  logic                     axi_rvalid,
   input  logic [pDATA_WIDTH-1:0]   axi_rdata,
   output logic                     axi_rready
);

   localparam int CW = $clog2(pTIMEOUT) + 1;
   localparam logic [CW-1:0] TMAX = CW'(pTIMEOUT);

   logic          ar_done;
   logic [CW-1:0] cnt;
   logic          aw_hs, ar_hs, r_hs, any_hs;

   // Address and data are held together and accepted only on a joint aw/w handshake.
   always_comb begin
      axi_awvalid = req && we;
      axi_wvalid  = axi_awvalid;
      axi_awaddr  = axi_awvalid ? addr : '0;
      axi_wdata   = axi_awvalid ? wdata : '0;
      axi_wstrb   = {(pDATA_WIDTH/8){axi_awvalid}};
      axi_arvalid = req && !we && !ar_done;
      axi_araddr  = axi_arvalid ? addr : '0;
      axi_rready  = req && !we;
      aw_hs       = axi_awvalid && axi_awready && axi_wready;
      ar_hs       = axi_arvalid && axi_arready;
      // ar_done is registered, so read data is only taken strictly after the AR handshake
      r_hs        = axi_rready && axi_rvalid && ar_done;
      any_hs      = aw_hs || ar_hs || r_hs;
      ack         = aw_hs || r_hs;
      rdata       = r_hs ? axi_rdata : '0;
      // a handshake landing in the final cycle wins over the timeout
      timeout     = req && !any_hs && cnt == TMAX;
   end

   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         cnt     <= '0;
         ar_done <= 1'b0;
      end else begin
         cnt     <= (!req || any_hs) ? '0 : (cnt == TMAX ? cnt : cnt + CW'(1));
         ar_done <= req && !we && !r_hs && (ar_done || ar_hs);
      end
   end

endmodule

// File: rtl/fsic_io_serdes_link_init.sv
// fsic_io_serdes_link_init: AXI-Lite master that brings the IO serdes link up (rxen, then txen).
//   axi_clk, axi_reset_n   clock, async active-low reset
//   start                  level-sampled bring-up request (ignored while busy)
//   axi_*                  AXI-Lite master to the serdes config slave
//   cc_ls_enable           config-port enable, high while a transfer state is active
//   busy, done, error      sequence status levels
//   err_code               00 none, 01 handshake timeout, 10 retries exhausted
module fsic_io_serdes_link_init
   import fsic_io_serdes_pkg::*;
#(
   parameter int pADDR_WIDTH  = 10,
   parameter int pDATA_WIDTH  = 32,
   parameter int pCTRL_OFFSET = 0,
   parameter int pTX_DELAY    = 16,
   parameter int pTIMEOUT     = 255,
   parameter int pRETRY       = 3
) (
   input  logic                     axi_clk,
   input  logic                     axi_reset_n,
   input  logic                     start,
   output logic                     axi_awvalid,
   output logic [pADDR_WIDTH-1:0]   axi_awaddr,
   input  logic                     axi_awready,
   output logic                     axi_wvalid,
   output logic [pDATA_WIDTH-1:0]   axi_wdata,
   output logic [pDATA_WIDTH/8-1:0] axi_wstrb,
   input  logic                     axi_wready,
   output logic                     axi_arvalid,
   output logic [pADDR_WIDTH-1:0]   axi_araddr,
   input  logic                     axi_arready,
   input  logic                     axi_rvalid,
   input  logic [pDATA_WIDTH-1:0]   axi_rdata,
   output logic                     axi_rready,
   output logic                     cc_ls_enable,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic [1:0]               err_code
);

   localparam int WW = $clog2(pTX_DELAY) + 1;
   localparam int RW = $clog2(pRETRY) + 1;
   localparam logic [WW-1:0] WLOAD = WW'(pTX_DELAY);
   localparam logic [RW-1:0] RMAX = RW'(pRETRY);
   localparam logic [pADDR_WIDTH-1:0] CTRL_ADDR = pADDR_WIDTH'(pCTRL_OFFSET);

   state_t                 state, nxt;
   logic [WW-1:0]          wait_cnt;
   logic [RW-1:0]          retry_cnt, retry_nxt;
   logic [1:0]             code_nxt;
   logic                   is_tx, is_wr, rd_ok;
   logic                   ack, timeout;
   logic [pDATA_WIDTH-1:0] rdata, wr_data;
   logic                   unused_rdata;

   assign unused_rdata = ^rdata[pDATA_WIDTH-1:2];

   always_comb begin
      is_tx        = state inside {ST_WR_TX, ST_RD_TX};
      is_wr        = state inside {ST_WR_RX, ST_WR_TX};
      cc_ls_enable = state inside {ST_WR_RX, ST_RD_RX, ST_WR_TX, ST_RD_TX};
      busy         = !(state inside {ST_IDLE, ST_DONE, ST_ERR});
      done         = state == ST_DONE;
      error        = state == ST_ERR;
      wr_data                = '0;
      wr_data[CTRL_RXEN_BIT] = 1'b1;
      wr_data[CTRL_TXEN_BIT] = is_tx;
      // the tx step must see both enables set; the rx step only needs rxen
      rd_ok = rdata[CTRL_RXEN_BIT] && (!is_tx || rdata[CTRL_TXEN_BIT]);
      nxt       = state;
      retry_nxt = retry_cnt;
      code_nxt  = err_code;
      case (state)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               nxt       = ST_WR_RX;
               retry_nxt = '0;
               code_nxt  = ERR_NONE;
            end
         end
         ST_WR_RX, ST_WR_TX: begin
            if (timeout) begin
               nxt      = ST_ERR;
               code_nxt = ERR_TIMEOUT;
            end else if (ack) begin
               nxt = is_tx ? ST_RD_TX : ST_RD_RX;
            end
         end
         ST_RD_RX, ST_RD_TX: begin
            if (timeout) begin
               nxt      = ST_ERR;
               code_nxt = ERR_TIMEOUT;
            end else if (ack && rd_ok) begin
               nxt       = is_tx ? ST_DONE : ST_WAIT;
               retry_nxt = '0;
            end else if (ack && retry_cnt >= RMAX) begin
               nxt      = ST_ERR;
               code_nxt = ERR_RETRY;
            end else if (ack) begin
               nxt       = is_tx ? ST_WR_TX : ST_WR_RX;
               retry_nxt = retry_cnt + RW'(1);
            end
         end
         ST_WAIT: nxt = wait_cnt == WW'(1) ? ST_WR_TX : ST_WAIT;
         default: nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         state     <= ST_IDLE;
         wait_cnt  <= '0;
         retry_cnt <= '0;
         err_code  <= ERR_NONE;
      end else begin
         state     <= nxt;
         wait_cnt  <= (nxt == ST_WAIT && state != ST_WAIT) ? WLOAD :
                      (state == ST_WAIT ? wait_cnt - WW'(1) : wait_cnt);
         retry_cnt <= retry_nxt;
         err_code  <= code_nxt;
      end
   end

   fsic_axil_single_xfer #(
      .pADDR_WIDTH (pADDR_WIDTH),
      .pDATA_WIDTH (pDATA_WIDTH),
      .pTIMEOUT    (pTIMEOUT)
   ) u_xfer (
      .axi_clk     (axi_clk),
      .axi_reset_n (axi_reset_n),
      .req         (cc_ls_enable),
      .we          (is_wr),
      .addr        (CTRL_ADDR),
      .wdata       (wr_data),
      .ack         (ack),
      .rdata       (rdata),
      .timeout     (timeout),
      .axi_awvalid (axi_awvalid),
      .axi_awaddr  (axi_awaddr),
      .axi_awready (axi_awready),
      .axi_wvalid  (axi_wvalid),
      .axi_wdata   (axi_wdata),
      .axi_wstrb   (axi_wstrb),
      .axi_wready  (axi_wready),
      .axi_arvalid (axi_arvalid),
      .axi_araddr  (axi_araddr),
      .axi_arready (axi_arready),
      .axi_rvalid  (axi_rvalid),
      .axi_rdata   (axi_rdata),
      .axi_rready  (axi_rready)
   );

endmodule
